// File: rtl/name_entry_controller_pkg.sv
// Name entry shared definitions.
// Key codes, FSM states and key classification helpers.
package name_entry_controller_pkg;

    localparam logic [7:0] KEY_ENTER   = 8'h0D;
    localparam logic [7:0] KEY_BKSP    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ENTRY,
        DONE
    } state_t;

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return c >= 8'h20 && c <= 8'h7E;
    endfunction

endpackage

// File: rtl/name_store.sv
// Two-player name storage, MAX_LEN chars each, not reset.
// Ports: sync write (we, wr_player, wr_addr, wr_data); comb read (rd_*).
import name_entry_controller_pkg::*;

module name_store #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic             wr_player,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             rd_player,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_char
);

    logic [7:0] mem [2][MAX_LEN];

    always_ff @(posedge clock) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (we && wr_addr == LEN_W'(i))
                mem[wr_player][i] <= wr_data;
        end
    end

    // Addresses at or beyond MAX_LEN read back as blanks.
    always_comb begin
        rd_char = ASCII_SPACE;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_addr == LEN_W'(i))
                rd_char = mem[rd_player][i];
        end
    end

endmodule

// File: rtl/name_entry_controller.sv
// Player name entry: clear slot, collect keys, commit on enter.
// Ports: clock/resetn, user_name_req, key_*, rd_* view port, status outs.
import name_entry_controller_pkg::*;

module name_entry_controller #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       user_name_req,
    input  logic             key_valid,
    input  logic [7:0]       key_ascii,
    input  logic             rd_player,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_char,
    output logic             name_done,
    output logic             busy,
    output logic             cur_player,
    output logic [LEN_W-1:0] cursor,
    output logic [LEN_W-1:0] name_len_p1,
    output logic [LEN_W-1:0] name_len_p2
);

    localparam logic [LEN_W-1:0] LAST = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    state_t           state;
    logic [LEN_W-1:0] clr_idx;

    logic             key_do;
    logic             acc_char;
    logic             acc_bksp;
    logic             acc_enter;
    logic [7:0]       key_ch;

    logic             we;
    logic [LEN_W-1:0] wr_addr;
    logic [7:0]       wr_data;

    always_comb begin
        key_do    = (state == ENTRY) && key_valid;
        key_ch    = fold_upper(key_ascii);
        acc_char  = key_do && is_printable(key_ascii)
                    && cursor != FULL;
        acc_bksp  = key_do && key_ascii == KEY_BKSP
                    && cursor != '0;
        acc_enter = key_do && key_ascii == KEY_ENTER
                    && cursor != '0;
    end

    always_comb begin
        we      = 1'b0;
        wr_addr = '0;
        wr_data = ASCII_SPACE;
        unique case (1'b1)
            state == CLEAR: begin
                we      = 1'b1;
                wr_addr = clr_idx;
            end
            acc_char: begin
                we      = 1'b1;
                wr_addr = cursor;
                wr_data = key_ch;
            end
            acc_bksp: begin
                we      = 1'b1;
                wr_addr = cursor - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            clr_idx     <= '0;
            cursor      <= '0;
            cur_player  <= 1'b0;
            name_len_p1 <= '0;
            name_len_p2 <= '0;
            name_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            name_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (user_name_req[1]) begin
                        cur_player <= user_name_req[0];
                        clr_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST) begin
                        cursor <= '0;
                        state  <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (acc_char) begin
                        cursor <= cursor + 1'b1;
                    end else if (acc_bksp) begin
                        cursor <= cursor - 1'b1;
                    end else if (acc_enter) begin
                        if (cur_player)
                            name_len_p2 <= cursor;
                        else
                            name_len_p1 <= cursor;
                        name_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    name_store #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) u_store (
        .clock    (clock),
        .we       (we),
        .wr_player(cur_player),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_player(rd_player),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char)
    );

endmodule

// File: tb/tb_name_entry_controller.sv
// Scoreboarded bench for name_entry_controller.
// Reference model of slots/lengths; name_done events via queue.
module tb_name_entry_controller;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [1:0]       user_name_req = 2'b00;
    logic             key_valid = 1'b0;
    logic [7:0]       key_ascii = 8'h00;
    logic             rd_player = 1'b0;
    logic [LEN_W-1:0] rd_addr = '0;
    logic [7:0]       rd_char;
    logic             name_done;
    logic             busy;
    logic             cur_player;
    logic [LEN_W-1:0] cursor;
    logic [LEN_W-1:0] name_len_p1;
    logic [LEN_W-1:0] name_len_p2;

    name_entry_controller #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .user_name_req(user_name_req),
        .key_valid    (key_valid),
        .key_ascii    (key_ascii),
        .rd_player    (rd_player),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .name_done    (name_done),
        .busy         (busy),
        .cur_player   (cur_player),
        .cursor       (cursor),
        .name_len_p1  (name_len_p1),
        .name_len_p2  (name_len_p2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic p;
        int   len;
    } done_t;

    done_t sb[$];

    int   vectors = 0;
    int   errors  = 0;
    logic [7:0] m_mem [2][MAX_LEN];
    int   m_len [2];
    int   m_cur;
    logic m_p;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (resetn && name_done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                done_t d;
                d = sb.pop_front();
                check("done_player", int'(cur_player), int'(d.p));
                check("done_len_p1", int'(name_len_p1), m_len[0]);
                check("done_len_p2", int'(name_len_p2), m_len[1]);
                check("done_len_cur",
                      d.p ? int'(name_len_p2) : int'(name_len_p1),
                      d.len);
            end
        end
    end

    task automatic check_slot(input logic p);
        rd_player = p;
        for (int i = 0; i <= MAX_LEN; i++) begin
            rd_addr = LEN_W'(i);
            #1;
            check($sformatf("rd_p%0d_%0d", p, i), int'(rd_char),
                  i < MAX_LEN ? int'(m_mem[p][i]) : 32'h20);
        end
        rd_addr = 4'hF;
        #1;
        check("rd_addr_max", int'(rd_char), 32'h20);
    endtask

    // Request an edit; a key is sent in the last CLEAR cycle and must be dropped.
    task automatic request(input logic p, input bit hold);
        user_name_req = {1'b1, p};
        tick();
        if (!hold) user_name_req = 2'b00;
        check("req_busy", int'(busy), 1);
        check("req_player", int'(cur_player), int'(p));
        for (int i = 0; i < MAX_LEN - 2; i++) begin
            tick();
            check("clear_busy", int'(busy), 1);
        end
        tick();
        key_valid = 1'b1;
        key_ascii = 8'h51;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) m_mem[p][i] = 8'h20;
        m_cur = 0;
        m_p = p;
        check("entry_busy", int'(busy), 1);
        check("entry_cursor", int'(cursor), 0);
    endtask

    task automatic key(input logic [7:0] k);
        logic [7:0] c;
        bit exp_done;
        done_t d;
        exp_done = 0;
        c = (k >= 8'h61 && k <= 8'h7A) ? k - 8'h20 : k;
        if (k >= 8'h20 && k <= 8'h7E) begin
            if (m_cur < MAX_LEN) begin
                m_mem[m_p][m_cur] = c;
                m_cur++;
            end
        end else if (k == 8'h08 && m_cur > 0) begin
            m_cur--;
            m_mem[m_p][m_cur] = 8'h20;
        end else if (k == 8'h0D && m_cur > 0) begin
            m_len[m_p] = m_cur;
            d.p = m_p;
            d.len = m_cur;
            sb.push_back(d);
            exp_done = 1;
        end
        key_valid = 1'b1;
        key_ascii = k;
        tick();
        key_valid = 1'b0;
        check($sformatf("done_after_%02h", k), int'(name_done),
              int'(exp_done));
        if (exp_done) begin
            check("done_busy", int'(busy), 0);
            tick();
            check("done_pulse_end", int'(name_done), 0);
        end else begin
            check($sformatf("cursor_after_%02h", k), int'(cursor), m_cur);
        end
    endtask

    initial begin
        m_len[0] = 0;
        m_len[1] = 0;
        m_cur = 0;
        m_p = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m_mem[0][i] = 8'h20;
            m_mem[1][i] = 8'h20;
        end

        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(name_done), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_player", int'(cur_player), 0);
        check("rst_len_p1", int'(name_len_p1), 0);
        check("rst_len_p2", int'(name_len_p2), 0);
        resetn = 1'b1;
        tick();

        // Keys in IDLE are ignored.
        key_valid = 1'b1;
        key_ascii = 8'h41;
        tick();
        key_valid = 1'b0;
        check("idle_key_busy", int'(busy), 0);

        request(1'b0, 1'b0);
        check_slot(1'b0);
        key(8'h62);
        key(8'h4F);
        key(8'h62);
        key(8'h0D);
        check_slot(1'b0);
        check("bob_len", int'(name_len_p1), 3);

        request(1'b0, 1'b0);
        key(8'h0D);
        for (int i = 0; i < MAX_LEN + 1; i++) key(8'h41);
        check("full_cursor", int'(cursor), MAX_LEN);
        check_slot(1'b0);
        key(8'h0D);
        check("full_len", int'(name_len_p1), MAX_LEN);

        request(1'b0, 1'b0);
        key(8'h41);
        key(8'h42);
        key(8'h08);
        key(8'h08);
        key(8'h08);
        check("bksp_cursor", int'(cursor), 0);
        key(8'h01);
        key(8'h7F);
        key(8'h7E);
        key(8'h63);
        check_slot(1'b0);
        key(8'h0D);

        request(1'b1, 1'b1);
        key(8'h7A);
        check("hold_cursor", int'(cursor), 1);
        key(8'h0D);
        user_name_req = 2'b00;
        check("p2_len", int'(name_len_p2), 1);
        check("p1_keep", int'(name_len_p1), 2);
        check_slot(1'b1);
        check_slot(1'b0);

        request(1'b0, 1'b0);
        key(8'h41);
        key(8'h42);
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_len_p1", int'(name_len_p1), 0);
        check("mid_rst_len_p2", int'(name_len_p2), 0);
        check("mid_rst_cursor", int'(cursor), 0);
        m_len[0] = 0;
        m_len[1] = 0;
        tick();
        resetn = 1'b1;
        tick();
        check("post_rst_busy", int'(busy), 0);
        check_slot(1'b0);
        check_slot(1'b1);

        repeat (3) tick();
        check("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
